// File: rtl/cgra_dtl_pkg.sv
// Shared DTL target definitions: FSM encoding, command direction codes and
// default bus geometry.
package cgra_dtl_pkg;

  localparam int unsigned DTL_IW  = 32;
  localparam int unsigned DTL_IAW = 32;
  localparam int unsigned DTL_IBW = 5;
  localparam int unsigned DTL_MAW = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  localparam logic DTL_RD = 1'b0;
  localparam logic DTL_WR = 1'b1;

  // Beat counter must hold BlockSize+1, so it is one bit wider than the field.
  function automatic int unsigned dtl_cnt_width(input int unsigned block_width);
    return block_width + 1;
  endfunction

endpackage

// File: rtl/cgra_dtl_mem_target_if.sv
// DTL command/write/read channel bundle between a CGRA master and a memory target.
interface cgra_dtl_mem_target_if #(
  parameter int unsigned INTERFACE_WIDTH       = cgra_dtl_pkg::DTL_IW,
  parameter int unsigned INTERFACE_ADDR_WIDTH  = cgra_dtl_pkg::DTL_IAW,
  parameter int unsigned INTERFACE_BLOCK_WIDTH = cgra_dtl_pkg::DTL_IBW
) ();

  logic                               iDTL_CommandValid;
  logic                               oDTL_CommandAccept;
  logic                               iDTL_CommandReadWrite;
  logic [INTERFACE_ADDR_WIDTH-1:0]    iDTL_Address;
  logic [INTERFACE_BLOCK_WIDTH-1:0]   iDTL_BlockSize;
  logic                               iDTL_WriteValid;
  logic                               oDTL_WriteAccept;
  logic [INTERFACE_WIDTH-1:0]         iDTL_WriteData;
  logic [INTERFACE_WIDTH/8-1:0]       iDTL_WriteEnable;
  logic                               iDTL_WriteLast;
  logic                               oDTL_ReadValid;
  logic                               iDTL_ReadAccept;
  logic [INTERFACE_WIDTH-1:0]         oDTL_ReadData;
  logic                               oDTL_ReadLast;

  modport master (
    output iDTL_CommandValid, iDTL_CommandReadWrite, iDTL_Address, iDTL_BlockSize,
    output iDTL_WriteValid, iDTL_WriteData, iDTL_WriteEnable, iDTL_WriteLast,
    output iDTL_ReadAccept,
    input  oDTL_CommandAccept, oDTL_WriteAccept, oDTL_ReadValid, oDTL_ReadData, oDTL_ReadLast
  );

  modport slave (
    input  iDTL_CommandValid, iDTL_CommandReadWrite, iDTL_Address, iDTL_BlockSize,
    input  iDTL_WriteValid, iDTL_WriteData, iDTL_WriteEnable, iDTL_WriteLast,
    input  iDTL_ReadAccept,
    output oDTL_CommandAccept, oDTL_WriteAccept, oDTL_ReadValid, oDTL_ReadData, oDTL_ReadLast
  );

endinterface

// File: rtl/cgra_dtl_target_sram.sv
// Single-port word SRAM with per-byte write enables and a registered read port
// that holds its last value while re is low.
module cgra_dtl_target_sram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    re,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cgra_dtl_mem_target.sv
// DTL slave backed by an internal SRAM: single and burst reads/writes with
// ReadAccept back-pressure and a sticky burst-length error flag.
module cgra_dtl_mem_target
  import cgra_dtl_pkg::*;
#(
  parameter int unsigned INTERFACE_WIDTH       = DTL_IW,
  parameter int unsigned INTERFACE_ADDR_WIDTH  = DTL_IAW,
  parameter int unsigned INTERFACE_BLOCK_WIDTH = DTL_IBW,
  parameter int unsigned MEM_ADDR_WIDTH        = DTL_MAW
) (
  input  logic                        iClk,
  input  logic                        iReset,
  cgra_dtl_mem_target_if.slave        dtl,
  output logic                        oError
);

  localparam int unsigned NB  = INTERFACE_WIDTH / 8;
  localparam int unsigned CW  = dtl_cnt_width(INTERFACE_BLOCK_WIDTH);
  localparam int unsigned MAW = MEM_ADDR_WIDTH;

  logic [1:0]     state_q, state_d;
  logic [MAW-1:0] addr_q, addr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rvalid_q, rvalid_d;
  logic           rlast_q, rlast_d;
  logic           error_q, error_d;

  logic                       sram_re;
  logic                       sram_we;
  logic [MAW-1:0]             sram_addr;
  logic [INTERFACE_WIDTH-1:0] sram_rdata;
  logic [MAW-1:0]             cmd_word;
  logic                       unused_addr_bits;

  // Only the word index inside the array is decoded; byte offset and upper bits alias.
  assign cmd_word         = dtl.iDTL_Address[MAW+1:2];
  assign unused_addr_bits = ^{dtl.iDTL_Address[INTERFACE_ADDR_WIDTH-1:MAW+2],
                              dtl.iDTL_Address[1:0]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    error_d   = error_q;
    sram_re   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = addr_q;

    case (state_q)
      ST_IDLE: begin
        sram_addr = cmd_word;
        if (dtl.iDTL_CommandValid) begin
          cnt_d = CW'(dtl.iDTL_BlockSize) + CW'(1);
          if (dtl.iDTL_CommandReadWrite == DTL_WR) begin
            addr_d  = cmd_word;
            state_d = ST_WRITE;
          end else begin
            // First word is fetched in the accept cycle so it is valid one cycle later.
            sram_re  = 1'b1;
            addr_d   = cmd_word + MAW'(1);
            rvalid_d = 1'b1;
            rlast_d  = (dtl.iDTL_BlockSize == '0);
            state_d  = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        if (dtl.iDTL_WriteValid) begin
          sram_we = 1'b1;
          addr_d  = addr_q + MAW'(1);
          cnt_d   = cnt_q - CW'(1);
          if (dtl.iDTL_WriteLast) begin
            state_d = ST_IDLE;
            if (cnt_q != CW'(1)) error_d = 1'b1;
          end else if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (rvalid_q && dtl.iDTL_ReadAccept) begin
          if (rlast_q) begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            sram_re = 1'b1;
            addr_d  = addr_q + MAW'(1);
            cnt_d   = cnt_q - CW'(1);
            rlast_d = (cnt_q == CW'(2));
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      error_q  <= error_d;
    end
  end

  cgra_dtl_target_sram #(
    .DATA_WIDTH (INTERFACE_WIDTH),
    .ADDR_WIDTH (MAW)
  ) u_sram (
    .clk   (iClk),
    .rst_n (iReset),
    .re    (sram_re),
    .we    (sram_we),
    .addr  (sram_addr),
    .be    (dtl.iDTL_WriteEnable[NB-1:0]),
    .wdata (dtl.iDTL_WriteData),
    .rdata (sram_rdata)
  );

  assign dtl.oDTL_CommandAccept = (state_q == ST_IDLE);
  assign dtl.oDTL_WriteAccept   = (state_q == ST_WRITE);
  assign dtl.oDTL_ReadValid     = rvalid_q;
  assign dtl.oDTL_ReadLast      = rlast_q;
  assign dtl.oDTL_ReadData      = sram_rdata;
  assign oError                 = error_q;

endmodule
